// File: rtl/io_interface.sv
// Keyboard/display I/O port for a small accumulator machine: INPR/FGI on the
// input side, OUTR/FGO plus a two-state display sender on the output side.
module io_interface (
    input  logic        clk,
    input  logic        reset,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [7:0]  ac_in,
    output logic [15:0] io_data_out,
    input  logic        ien_set,
    input  logic        ien_clr,
    output logic        fgi,
    output logic        fgo,
    output logic        keyboard_interrupt,
    output logic        overrun_err
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; the sender keeps valid and data stable until that edge.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] inpr_q, inpr_d;
    logic [7:0] outr_q, outr_d;
    logic       fgi_q, fgi_d;
    logic       fgo_q, fgo_d;
    logic       ien_q, ien_d;
    logic       ovr_q, ovr_d;
    logic       kbd_accept;

    assign kbd_accept = kbd_valid & ~fgi_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            inpr_q  <= 8'h00;
            outr_q  <= 8'h00;
            fgi_q   <= 1'b0;
            fgo_q   <= 1'b1;
            ien_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inpr_q  <= inpr_d;
            outr_q  <= outr_d;
            fgi_q   <= fgi_d;
            fgo_q   <= fgo_d;
            ien_q   <= ien_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        inpr_d  = inpr_q;
        outr_d  = outr_q;
        fgi_d   = fgi_q;
        fgo_d   = fgo_q;
        ien_d   = ien_q;
        ovr_d   = ovr_q;

        // A keyboard load placed after the read clear lets the load win.
        if (io_read && fgi_q) begin
            fgi_d = 1'b0;
        end
        if (kbd_accept) begin
            inpr_d = kbd_data;
            fgi_d  = 1'b1;
        end

        if (io_write) begin
            if (fgo_q && state_q == IDLE) begin
                outr_d  = ac_in;
                fgo_d   = 1'b0;
                state_d = SEND;
            end else if (!fgo_q) begin
                ovr_d = 1'b1;
            end
        end

        if (state_q == SEND && disp_ready) begin
            state_d = IDLE;
            fgo_d   = 1'b1;
        end

        if (ien_clr) begin
            ien_d = 1'b0;
        end else if (ien_set) begin
            ien_d = 1'b1;
        end
    end

    assign kbd_ready          = ~fgi_q;
    assign io_data_out        = {8'h00, inpr_q};
    assign disp_valid         = (state_q == SEND);
    assign disp_data          = outr_q;
    assign fgi                = fgi_q;
    assign fgo                = fgo_q;
    assign keyboard_interrupt = ien_q & fgi_q;
    assign overrun_err        = ovr_q;

endmodule

// File: tb/tb_io_interface.sv
// Bench for io_interface: directed scenarios followed by random traffic
// checked against a flag-level reference model with a display scoreboard.
module tb_io_interface;

    logic        clk;
    logic        reset;
    logic        kbd_valid;
    logic [7:0]  kbd_data;
    logic        kbd_ready;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready;
    logic        io_read;
    logic        io_write;
    logic [7:0]  ac_in;
    logic [15:0] io_data_out;
    logic        ien_set;
    logic        ien_clr;
    logic        fgi;
    logic        fgo;
    logic        keyboard_interrupt;
    logic        overrun_err;

    int total = 0;
    int bad   = 0;

    // Characters the model expects to appear at the display, in order.
    logic [7:0] exp_q[$];

    io_interface dut (
        .clk                (clk),
        .reset              (reset),
        .kbd_valid          (kbd_valid),
        .kbd_data           (kbd_data),
        .kbd_ready          (kbd_ready),
        .disp_valid         (disp_valid),
        .disp_data          (disp_data),
        .disp_ready         (disp_ready),
        .io_read            (io_read),
        .io_write           (io_write),
        .ac_in              (ac_in),
        .io_data_out        (io_data_out),
        .ien_set            (ien_set),
        .ien_clr            (ien_clr),
        .fgi                (fgi),
        .fgo                (fgo),
        .keyboard_interrupt (keyboard_interrupt),
        .overrun_err        (overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        kbd_valid  = 1'b0;
        kbd_data   = 8'h00;
        disp_ready = 1'b0;
        io_read    = 1'b0;
        io_write   = 1'b0;
        ac_in      = 8'h00;
        ien_set    = 1'b0;
        ien_clr    = 1'b0;
    endtask

    // One clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        #3 reset = 1'b1;
        tick();
        tick();
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        total++;
        if (kbd_ready !== 1'b1) begin bad++; $display("FAIL rst_kbd_ready got=%b want=1", kbd_ready); end
        total++;
        if (disp_valid !== 1'b0) begin bad++; $display("FAIL rst_disp_valid got=%b want=0", disp_valid); end
        total++;
        if (keyboard_interrupt !== 1'b0) begin bad++; $display("FAIL rst_kint got=%b want=0", keyboard_interrupt); end
        total++;
        if ({fgi, fgo, overrun_err} !== 3'b010) begin bad++; $display("FAIL rst_flags got=%b want=010", {fgi, fgo, overrun_err}); end
        total++;
        if (io_data_out !== 16'h0000 || disp_data !== 8'h00) begin
            bad++; $display("FAIL rst_regs got=%h/%h want=0000/00", io_data_out, disp_data);
        end
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic test_kbd_input();
        kbd_valid = 1'b1;
        kbd_data  = 8'h41;
        tick();
        kbd_valid = 1'b0;
        kbd_data  = 8'h99;
        total++;
        if (fgi !== 1'b1 || kbd_ready !== 1'b0) begin
            bad++; $display("FAIL kbd_flags got fgi=%b rdy=%b want fgi=1 rdy=0", fgi, kbd_ready);
        end
        total++;
        if (io_data_out !== 16'h0041) begin bad++; $display("FAIL kbd_data got=%h want=0041", io_data_out); end
        // A character offered while FGI is set must be ignored.
        kbd_valid = 1'b1;
        tick();
        kbd_valid = 1'b0;
        total++;
        if (io_data_out !== 16'h0041) begin bad++; $display("FAIL kbd_blocked got=%h want=0041", io_data_out); end
    endtask

    task automatic test_interrupt();
        ien_set = 1'b1;
        tick();
        ien_set = 1'b0;
        total++;
        if (keyboard_interrupt !== 1'b1) begin bad++; $display("FAIL int_set got=%b want=1", keyboard_interrupt); end
        io_read = 1'b1;
        tick();
        io_read = 1'b0;
        total++;
        if (fgi !== 1'b0 || keyboard_interrupt !== 1'b0 || kbd_ready !== 1'b1) begin
            bad++; $display("FAIL int_read got fgi=%b kint=%b rdy=%b want 0 0 1", fgi, keyboard_interrupt, kbd_ready);
        end
        total++;
        if (io_data_out !== 16'h0041) begin bad++; $display("FAIL int_inpr_hold got=%h want=0041", io_data_out); end
    endtask

    task automatic test_read_load_race();
        io_read   = 1'b1;
        kbd_valid = 1'b1;
        kbd_data  = 8'h62;
        tick();
        io_read   = 1'b0;
        kbd_valid = 1'b0;
        total++;
        if (fgi !== 1'b1 || io_data_out !== 16'h0062) begin
            bad++; $display("FAIL race_load got fgi=%b data=%h want 1 0062", fgi, io_data_out);
        end
        io_read = 1'b1;
        tick();
        io_read = 1'b0;
    endtask

    task automatic test_output();
        ac_in    = 8'h5A;
        io_write = 1'b1;
        tick();
        io_write = 1'b0;
        ac_in    = 8'h00;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (disp_valid !== 1'b1 || disp_data !== 8'h5A || fgo !== 1'b0) begin
                bad++; $display("FAIL out_hold cyc=%0d got v=%b d=%h fgo=%b want 1 5a 0", i, disp_valid, disp_data, fgo);
            end
            if (i == 3) disp_ready = 1'b1;
            tick();
        end
        disp_ready = 1'b0;
        total++;
        if (fgo !== 1'b1 || disp_valid !== 1'b0) begin
            bad++; $display("FAIL out_done got fgo=%b v=%b want 1 0", fgo, disp_valid);
        end
    endtask

    task automatic test_overrun();
        ac_in    = 8'h5A;
        io_write = 1'b1;
        tick();
        total++;
        if (overrun_err !== 1'b0) begin bad++; $display("FAIL ovr_early got=%b want=0", overrun_err); end
        ac_in = 8'hFF;
        tick();
        io_write = 1'b0;
        total++;
        if (overrun_err !== 1'b1 || disp_data !== 8'h5A || disp_valid !== 1'b1) begin
            bad++; $display("FAIL ovr_set got err=%b d=%h v=%b want 1 5a 1", overrun_err, disp_data, disp_valid);
        end
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
        tick();
        total++;
        if (overrun_err !== 1'b1 || fgo !== 1'b1) begin
            bad++; $display("FAIL ovr_sticky got err=%b fgo=%b want 1 1", overrun_err, fgo);
        end
    endtask

    task automatic test_ien_priority();
        kbd_valid = 1'b1;
        kbd_data  = 8'h7E;
        tick();
        kbd_valid = 1'b0;
        total++;
        if (keyboard_interrupt !== 1'b1) begin bad++; $display("FAIL ien_pre got=%b want=1", keyboard_interrupt); end
        ien_set = 1'b1;
        ien_clr = 1'b1;
        tick();
        ien_set = 1'b0;
        ien_clr = 1'b0;
        total++;
        if (fgi !== 1'b1 || keyboard_interrupt !== 1'b0) begin
            bad++; $display("FAIL ien_clr_wins got fgi=%b kint=%b want 1 0", fgi, keyboard_interrupt);
        end
    endtask

    task automatic test_reset_mid_send();
        ac_in    = 8'h33;
        io_write = 1'b1;
        tick();
        io_write = 1'b0;
        total++;
        if (disp_valid !== 1'b1 || disp_data !== 8'h33) begin
            bad++; $display("FAIL mid_send_pre got v=%b d=%h want 1 33", disp_valid, disp_data);
        end
        disp_ready = 1'b1;
        #2 reset = 1'b1;
        #1;
        total++;
        if (disp_valid !== 1'b0 || fgo !== 1'b1 || disp_data !== 8'h00) begin
            bad++; $display("FAIL mid_send_abort got v=%b fgo=%b d=%h want 0 1 00", disp_valid, fgo, disp_data);
        end
        total++;
        if (fgi !== 1'b0 || overrun_err !== 1'b0 || io_data_out !== 16'h0000) begin
            bad++; $display("FAIL mid_send_regs got fgi=%b err=%b in=%h want 0 0 0000", fgi, overrun_err, io_data_out);
        end
        tick();
        #2 reset = 1'b0;
        tick();
        tick();
        disp_ready = 1'b0;
        total++;
        if (disp_valid !== 1'b0 || fgo !== 1'b1) begin
            bad++; $display("FAIL mid_send_after got v=%b fgo=%b want 0 1", disp_valid, fgo);
        end
    endtask

    task automatic test_random();
        logic [7:0] m_inpr, m_outr;
        bit         m_fgi, m_fgo, m_ien, m_ovr, m_busy;
        int         sent;
        apply_reset();
        exp_q.delete();
        m_inpr = 8'h00; m_outr = 8'h00;
        m_fgi = 0; m_fgo = 1; m_ien = 0; m_ovr = 0; m_busy = 0;
        sent = 0;
        for (int n = 0; n < 400; n++) begin
            kbd_valid  = ($urandom_range(0, 1) == 1);
            kbd_data   = 8'($urandom);
            io_read    = ($urandom_range(0, 3) == 0);
            io_write   = ($urandom_range(0, 5) == 0);
            ac_in      = 8'($urandom);
            disp_ready = ($urandom_range(0, 1) == 1);
            ien_set    = ($urandom_range(0, 6) == 0);
            ien_clr    = ($urandom_range(0, 6) == 0);
            // A character is delivered when the display takes it.
            if (m_busy && disp_ready) begin
                total++;
                if (exp_q.size() == 0 || disp_data !== exp_q[0]) begin
                    bad++; $display("FAIL rnd_scoreboard n=%0d got=%h want=%h", n, disp_data,
                                    (exp_q.size() == 0) ? 8'hxx : exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                sent++;
            end
            begin
                bit n_fgi, n_fgo, n_busy, n_ien;
                n_fgi = m_fgi; n_fgo = m_fgo; n_busy = m_busy; n_ien = m_ien;
                if (io_read) n_fgi = 0;
                if (kbd_valid && !m_fgi) begin m_inpr = kbd_data; n_fgi = 1; end
                if (io_write && !m_fgo) m_ovr = 1;
                if (io_write && m_fgo) begin
                    m_outr = ac_in; n_fgo = 0; n_busy = 1; exp_q.push_back(ac_in);
                end
                if (m_busy && disp_ready) begin n_busy = 0; n_fgo = 1; end
                n_ien = ien_clr ? 0 : (ien_set ? 1 : m_ien);
                m_fgi = n_fgi; m_fgo = n_fgo; m_busy = n_busy; m_ien = n_ien;
            end
            tick();
            total++;
            if (fgi !== m_fgi || fgo !== m_fgo || overrun_err !== m_ovr ||
                kbd_ready !== !m_fgi || keyboard_interrupt !== (m_ien && m_fgi)) begin
                bad++; $display("FAIL rnd_flags n=%0d got fgi=%b fgo=%b err=%b rdy=%b kint=%b want %b %b %b %b %b",
                                n, fgi, fgo, overrun_err, kbd_ready, keyboard_interrupt,
                                m_fgi, m_fgo, m_ovr, !m_fgi, m_ien && m_fgi);
            end
            total++;
            if (io_data_out !== {8'h00, m_inpr} || disp_data !== m_outr || disp_valid !== m_busy) begin
                bad++; $display("FAIL rnd_data n=%0d got in=%h d=%h v=%b want %h %h %b",
                                n, io_data_out, disp_data, disp_valid, {8'h00, m_inpr}, m_outr, m_busy);
            end
        end
        idle_inputs();
        total++;
        if (sent < 5) begin bad++; $display("FAIL rnd_traffic got=%0d want>=5", sent); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_kbd_input();
        test_interrupt();
        test_read_load_race();
        test_output();
        test_overrun();
        test_ien_priority();
        test_reset_mid_send();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
